// File: rtl/time_counter.sv
// time_counter: timekeeping core of the digital clock.
// Divides clk down to a 1 Hz tick and keeps 24-hour hour/minute/second
// counters. A key-driven FSM steps through hour/minute/second set modes.
// Optional feature macro: HOURLY_CHIME_EN. When it is defined, chime is
// raised for CHIME_SECONDS ticks at each hour rollover. When it is undefined,
// chime is tied low.
module time_counter #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int CHIME_SECONDS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_key,
    input  logic       inc_key,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] set_field,
    output logic       tick_1hz,
    output logic       chime
);

    localparam int            PW     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PS_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] prescaler_r;
    logic [5:0]    hour_r;
    logic [5:0]    minute_r;
    logic [5:0]    second_r;
    logic          tick_s;

    logic          mode_sync1_r, mode_sync2_r, mode_prev_r, mode_edge_r;
    logic          inc_sync1_r, inc_sync2_r, inc_prev_r, inc_edge_r;

    // Increment with wrap to zero past max_v; values above max_v also fold to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        if (v >= max_v) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    // Key path: two-flop synchronizer, previous-value flop, registered rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync1_r <= 1'b0;
            mode_sync2_r <= 1'b0;
            mode_prev_r  <= 1'b0;
            mode_edge_r  <= 1'b0;
            inc_sync1_r  <= 1'b0;
            inc_sync2_r  <= 1'b0;
            inc_prev_r   <= 1'b0;
            inc_edge_r   <= 1'b0;
        end else begin
            mode_sync1_r <= mode_key;
            mode_sync2_r <= mode_sync1_r;
            mode_prev_r  <= mode_sync2_r;
            mode_edge_r  <= mode_sync2_r & ~mode_prev_r;
            inc_sync1_r  <= inc_key;
            inc_sync2_r  <= inc_sync1_r;
            inc_prev_r   <= inc_sync2_r;
            inc_edge_r   <= inc_sync2_r & ~inc_prev_r;
        end
    end

    // One-second tick: prescaler at its last count while running.
    always_comb begin
        tick_s = 1'b0;
        if ((state_r == ST_RUN) && (prescaler_r == PS_MAX)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Set-mode FSM, prescaler and time counters; mode edge outranks inc edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            prescaler_r <= {PW{1'b0}};
            hour_r      <= 6'd0;
            minute_r    <= 6'd0;
            second_r    <= 6'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (tick_s) begin
                        second_r <= wrap_inc(second_r, 6'd59);
                        if (second_r == 6'd59) begin
                            minute_r <= wrap_inc(minute_r, 6'd59);
                            if (minute_r == 6'd59) begin
                                hour_r <= wrap_inc(hour_r, 6'd23);
                            end
                        end
                    end
                    if (mode_edge_r) begin
                        state_r     <= ST_SET_HOUR;
                        prescaler_r <= {PW{1'b0}};
                    end else if (prescaler_r >= PS_MAX) begin
                        prescaler_r <= {PW{1'b0}};
                    end else begin
                        prescaler_r <= prescaler_r + PS_ONE;
                    end
                end
                ST_SET_HOUR: begin
                    prescaler_r <= {PW{1'b0}};
                    if (mode_edge_r) begin
                        state_r <= ST_SET_MIN;
                    end else if (inc_edge_r) begin
                        hour_r <= wrap_inc(hour_r, 6'd23);
                    end
                end
                ST_SET_MIN: begin
                    prescaler_r <= {PW{1'b0}};
                    if (mode_edge_r) begin
                        state_r <= ST_SET_SEC;
                    end else if (inc_edge_r) begin
                        minute_r <= wrap_inc(minute_r, 6'd59);
                    end
                end
                ST_SET_SEC: begin
                    // Prescaler stays at zero so the first tick lands a full period after RUN.
                    prescaler_r <= {PW{1'b0}};
                    if (mode_edge_r) begin
                        state_r <= ST_RUN;
                    end else if (inc_edge_r) begin
                        second_r <= wrap_inc(second_r, 6'd59);
                    end
                end
                default: begin
                    state_r     <= ST_RUN;
                    prescaler_r <= {PW{1'b0}};
                end
            endcase
        end
    end

`ifdef HOURLY_CHIME_EN
    localparam logic [5:0] CHIME_LAST = (CHIME_SECONDS > 0) ? 6'(CHIME_SECONDS - 1) : 6'd0;

    logic chime_r;

    // Hourly chime: rises on the minute 59->0 tick, drops after CHIME_SECONDS ticks or on any set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chime_r <= 1'b0;
        end else if ((state_r != ST_RUN) || mode_edge_r) begin
            chime_r <= 1'b0;
        end else if (tick_s && (second_r == 6'd59) && (minute_r == 6'd59)) begin
            chime_r <= 1'b1;
        end else if (tick_s && chime_r && (second_r == CHIME_LAST)) begin
            chime_r <= 1'b0;
        end else begin
            chime_r <= chime_r;
        end
    end

    assign chime = chime_r;
`else
    assign chime = 1'b0;
`endif

    assign hour      = hour_r;
    assign minute    = minute_r;
    assign second    = second_r;
    assign set_field = state_r;
    assign tick_1hz  = tick_s;

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter with CLK_FREQ = 4.
module tb_time_counter;

    logic       clk;
    logic       rst_n;
    logic       mode_key;
    logic       inc_key;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] set_field;
    logic       tick_1hz;
    logic       chime;

    int n_cmp;
    int n_bad;

    time_counter #(
        .CLK_FREQ      (4),
        .CHIME_SECONDS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_key  (mode_key),
        .inc_key   (inc_key),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .set_field (set_field),
        .tick_1hz  (tick_1hz),
        .chime     (chime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset for one edge and release it at a sample point.
    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    // Hold a key 4 edges (action lands on the 4th), then low for 3 edges.
    task automatic press(input bit use_mode, input bit use_inc);
        if (use_mode) mode_key = 1'b1;
        if (use_inc)  inc_key  = 1'b1;
        step(4);
        mode_key = 1'b0;
        inc_key  = 1'b0;
        step(3);
    endtask

    task automatic press_inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode_key = 1'b0;
        inc_key = 1'b0;
        step(2);
        n_cmp++; if (hour !== 6'd0) begin n_bad++; $display("FAIL reset_hour: got %0d want 0", hour); end
        n_cmp++; if (minute !== 6'd0) begin n_bad++; $display("FAIL reset_minute: got %0d want 0", minute); end
        n_cmp++; if (second !== 6'd0) begin n_bad++; $display("FAIL reset_second: got %0d want 0", second); end
        n_cmp++; if (set_field !== 2'd0) begin n_bad++; $display("FAIL reset_set_field: got %0d want 0", set_field); end
        n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %0b want 0", tick_1hz); end
        n_cmp++; if (chime !== 1'b0) begin n_bad++; $display("FAIL reset_chime: got %0b want 0", chime); end
        rst_n = 1'b1;
    endtask

    // 240 cycles of RUN straight out of reset: tick every 4th cycle, seconds 0..59.
    task automatic test_run_count();
        for (int i = 0; i < 240; i++) begin
            n_cmp++;
            if (tick_1hz !== ((i % 4) == 3)) begin
                n_bad++; $display("FAIL run_tick[%0d]: got %0b want %0b", i, tick_1hz, ((i % 4) == 3));
            end
            n_cmp++;
            if (second !== 6'((i / 4) % 60)) begin
                n_bad++; $display("FAIL run_second[%0d]: got %0d want %0d", i, second, (i / 4) % 60);
            end
            step(1);
        end
        n_cmp++; if (minute !== 6'd1) begin n_bad++; $display("FAIL run_minute_carry: got %0d want 1", minute); end
        n_cmp++; if (second !== 6'd0) begin n_bad++; $display("FAIL run_second_wrap: got %0d want 0", second); end
        n_cmp++; if (hour !== 6'd0) begin n_bad++; $display("FAIL run_hour: got %0d want 0", hour); end
    endtask

    // Field setting with wrap and no carry; entering SET from reset crosses one tick (second = 1).
    task automatic test_set_fields();
        do_reset();
        press(1'b1, 1'b0);
        n_cmp++; if (set_field !== 2'd1) begin n_bad++; $display("FAIL set_field_hour: got %0d want 1", set_field); end
        n_cmp++; if (second !== 6'd1) begin n_bad++; $display("FAIL set_entry_second: got %0d want 1", second); end
        press_inc_n(25);
        n_cmp++; if (hour !== 6'd1) begin n_bad++; $display("FAIL set_hour_wrap: got %0d want 1", hour); end
        n_cmp++; if (minute !== 6'd0) begin n_bad++; $display("FAIL set_hour_nocarry: got %0d want 0", minute); end
        press(1'b1, 1'b0);
        n_cmp++; if (set_field !== 2'd2) begin n_bad++; $display("FAIL set_field_min: got %0d want 2", set_field); end
        press_inc_n(61);
        n_cmp++; if (minute !== 6'd1) begin n_bad++; $display("FAIL set_min_wrap: got %0d want 1", minute); end
        n_cmp++; if (hour !== 6'd1) begin n_bad++; $display("FAIL set_min_nocarry: got %0d want 1", hour); end
        press(1'b1, 1'b0);
        n_cmp++; if (set_field !== 2'd3) begin n_bad++; $display("FAIL set_field_sec: got %0d want 3", set_field); end
        press_inc_n(3);
        n_cmp++; if (second !== 6'd4) begin n_bad++; $display("FAIL set_sec: got %0d want 4", second); end
        n_cmp++; if (minute !== 6'd1) begin n_bad++; $display("FAIL set_sec_nocarry: got %0d want 1", minute); end
    endtask

    // Preload 23:59:59, return to RUN, full rollover in one edge, then hourly chime length.
    task automatic test_rollover();
        int hi;
        do_reset();
        press(1'b1, 1'b0);
        press_inc_n(23);
        press(1'b1, 1'b0);
        press_inc_n(59);
        press(1'b1, 1'b0);
        press_inc_n(58);
        press(1'b1, 1'b0);
        // Three edges into RUN: prescaler at its last count.
        n_cmp++; if (set_field !== 2'd0) begin n_bad++; $display("FAIL roll_run: got %0d want 0", set_field); end
        n_cmp++; if (tick_1hz !== 1'b1) begin n_bad++; $display("FAIL roll_tick: got %0b want 1", tick_1hz); end
        n_cmp++; if ({hour, minute, second} !== {6'd23, 6'd59, 6'd59}) begin
            n_bad++; $display("FAIL roll_preload: got %0d:%0d:%0d want 23:59:59", hour, minute, second);
        end
        step(1);
        n_cmp++; if ({hour, minute, second} !== {6'd0, 6'd0, 6'd0}) begin
            n_bad++; $display("FAIL roll_wrap: got %0d:%0d:%0d want 0:0:0", hour, minute, second);
        end
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (chime === 1'b1) hi++;
            step(1);
        end
`ifdef HOURLY_CHIME_EN
        n_cmp++; if (hi !== 20) begin n_bad++; $display("FAIL chime_len: got %0d want 20", hi); end
`else
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL chime_len: got %0d want 0", hi); end
`endif
        n_cmp++; if ({hour, minute, second} !== {6'd0, 6'd0, 6'd10}) begin
            n_bad++; $display("FAIL roll_after: got %0d:%0d:%0d want 0:0:10", hour, minute, second);
        end
    endtask

    // Mode and inc on the same cycle: mode wins. Held inc gives one increment only.
    task automatic test_simultaneous();
        do_reset();
        press(1'b1, 1'b1);
        n_cmp++; if (set_field !== 2'd1) begin n_bad++; $display("FAIL simul_run_field: got %0d want 1", set_field); end
        n_cmp++; if (hour !== 6'd0) begin n_bad++; $display("FAIL simul_run_hour: got %0d want 0", hour); end
        inc_key = 1'b1;
        step(100);
        inc_key = 1'b0;
        step(3);
        n_cmp++; if (hour !== 6'd1) begin n_bad++; $display("FAIL held_inc_hour: got %0d want 1", hour); end
        press(1'b1, 1'b1);
        n_cmp++; if (set_field !== 2'd2) begin n_bad++; $display("FAIL simul_set_field: got %0d want 2", set_field); end
        n_cmp++; if (hour !== 6'd1) begin n_bad++; $display("FAIL simul_set_hour: got %0d want 1", hour); end
        n_cmp++; if (minute !== 6'd0) begin n_bad++; $display("FAIL simul_set_minute: got %0d want 0", minute); end
    endtask

    // SET holds time frozen with no tick; leaving SET_SEC restarts the prescaler from 0.
    task automatic test_freeze();
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL freeze_tick[%0d]: got 1 want 0", i); end
            step(1);
        end
        n_cmp++; if ({hour, minute, second} !== {6'd0, 6'd0, 6'd1}) begin
            n_bad++; $display("FAIL freeze_time: got %0d:%0d:%0d want 0:0:1", hour, minute, second);
        end
        press(1'b1, 1'b0);
        mode_key = 1'b1;
        step(3);
        n_cmp++; if (set_field !== 2'd3) begin n_bad++; $display("FAIL key_latency_early: got %0d want 3", set_field); end
        step(1);
        n_cmp++; if (set_field !== 2'd0) begin n_bad++; $display("FAIL key_latency: got %0d want 0", set_field); end
        n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL restart_tick0: got 1 want 0"); end
        mode_key = 1'b0;
        step(1);
        n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL restart_tick1: got 1 want 0"); end
        step(1);
        n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL restart_tick2: got 1 want 0"); end
        step(1);
        n_cmp++; if (tick_1hz !== 1'b1) begin n_bad++; $display("FAIL restart_tick3: got 0 want 1"); end
        n_cmp++; if (second !== 6'd1) begin n_bad++; $display("FAIL restart_sec_hold: got %0d want 1", second); end
        step(1);
        n_cmp++; if (second !== 6'd2) begin n_bad++; $display("FAIL restart_sec_inc: got %0d want 2", second); end
    endtask

    // Reset mid-set at 12:34:56 in SET_SEC clears everything before the next edge.
    task automatic test_reset_mid_set();
        do_reset();
        press(1'b1, 1'b0);
        press_inc_n(12);
        press(1'b1, 1'b0);
        press_inc_n(34);
        press(1'b1, 1'b0);
        press_inc_n(55);
        n_cmp++; if ({set_field, hour, minute, second} !== {2'd3, 6'd12, 6'd34, 6'd56}) begin
            n_bad++; $display("FAIL midset_preload: got f%0d %0d:%0d:%0d want f3 12:34:56", set_field, hour, minute, second);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++; if ({set_field, hour, minute, second, tick_1hz, chime} !== 22'd0) begin
            n_bad++; $display("FAIL midset_async_reset: got f%0d %0d:%0d:%0d t%0b c%0b want all 0",
                              set_field, hour, minute, second, tick_1hz, chime);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_run_count();
        test_set_fields();
        test_rollover();
        test_simultaneous();
        test_freeze();
        test_reset_mid_set();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
